sr_flag_arbiter: RTL

//   Shared bank of NFLAGS set/reset flags, each with SR-flip-flop semantics.

---
 rtl/sr_flag_pkg.sv | 17 +
 rtl/sr_arb_pick.sv | 48 ++++
 rtl/sr_flag_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sr_flag_pkg.sv
// Shared definitions for the SR flag arbiter.
//   sr_state_t : arbiter FSM states
//   OP_*       : per-requester {S,R} op encodings
package sr_flag_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        RESP
    } sr_state_t;

    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_ILL = 2'b11;

endpackage

// File: rtl/sr_arb_pick.sv
// Combinational grant picker for the SR flag arbiter.
// Build option: SR_RR_ARB_EN
//   defined   : round-robin, search starts at rr_ptr and wraps
//   undefined : fixed priority, lowest requester index wins (no rr_ptr port)
// Ports:
//   req     in   NREQ   request vector
//   rr_ptr  in   PTRW   round-robin start point (SR_RR_ARB_EN only)
//   gnt     out  NREQ   one-hot grant, all-zero when no request
//   gnt_id  out  PTRW   binary index of the granted requester
module sr_arb_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PTRW = 2
) (
    input  logic [NREQ-1:0] req,
`ifdef SR_RR_ARB_EN
    input  logic [PTRW-1:0] rr_ptr,
`endif
    output logic [NREQ-1:0] gnt,
    output logic [PTRW-1:0] gnt_id
);

    always_comb begin
        logic found;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
`ifdef SR_RR_ARB_EN
        for (int unsigned i = 0; i < NREQ; i++) begin
            logic [PTRW-1:0] j;
            j = PTRW'((32'(rr_ptr) + i) % NREQ);
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                gnt_id = j;
                found  = 1'b1;
            end
        end
`else
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                gnt_id = PTRW'(i);
                found  = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Shared bank of NFLAGS SR flags, written by NREQ requesters one op at a time.
// Each request is latched in IDLE, applied in APPLY, and answered with a registered
// one-cycle ack (with rdata/err) on the edge that leaves RESP.
// Build option: SR_RR_ARB_EN selects round-robin arbitration (default: fixed priority).
// Ports:
//   clk    in   1            clock, rising edge
//   rst_n  in   1            asynchronous active-low reset
//   req    in   NREQ         per-requester level request, held until ack
//   op     in   2*NREQ       per-requester {S,R}: 10 set, 01 clear, 00 read, 11 illegal
//   idx    in   NREQ*IDXW    per-requester flag index
//   ack    out  NREQ         one-cycle completion pulse to the winner
//   rdata  out  1            flag value after the op, valid with ack
//   err    out  1            illegal op or out-of-range idx, valid with ack
//   flags  out  NFLAGS       registered flag bank
//   busy   out  1            FSM not in IDLE
module sr_flag_arbiter
    import sr_flag_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned NFLAGS = 8,
    parameter int unsigned IDXW   = $clog2(NFLAGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [2*NREQ-1:0]      op,
    input  logic [NREQ*IDXW-1:0]   idx,
    output logic [NREQ-1:0]        ack,
    output logic                   rdata,
    output logic                   err,
    output logic [NFLAGS-1:0]      flags,
    output logic                   busy
);

    localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sr_state_t         state_q, state_d;
    logic [PTRW-1:0]   win_q, win_d;
    logic [1:0]        op_q, op_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              errl_q, errl_d;
    logic [NFLAGS-1:0] flags_q, flags_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   gnt;
    logic [PTRW-1:0]   gnt_id;
    logic [1:0]        sel_op;
    logic [IDXW-1:0]   sel_idx;
    logic              idx_ok;

`ifdef SR_RR_ARB_EN
    logic [PTRW-1:0]   rr_q, rr_d;
`endif

    sr_arb_pick #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_pick (
        .req    (req),
`ifdef SR_RR_ARB_EN
        .rr_ptr (rr_q),
`endif
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // One-hot mux of the winner's op/idx.
    always_comb begin
        sel_op  = '0;
        sel_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sel_op  |= op[2*i +: 2] & {2{gnt[i]}};
            sel_idx |= idx[IDXW*i +: IDXW] & {IDXW{gnt[i]}};
        end
    end

    // Only reachable when NFLAGS is not a power of two.
    assign idx_ok = (32'(idx_q) < NFLAGS);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        op_d    = op_q;
        idx_d   = idx_q;
        errl_d  = errl_q;
        flags_d = flags_q;
        ack_d   = '0;
        rdata_d = 1'b0;
        err_d   = 1'b0;
`ifdef SR_RR_ARB_EN
        rr_d    = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = APPLY;
                    win_d   = gnt_id;
                    op_d    = sel_op;
                    idx_d   = sel_idx;
                    errl_d  = 1'b0;
                end
            end
            APPLY: begin
                state_d = RESP;
                if (op_q == OP_ILL || !idx_ok) begin
                    errl_d = 1'b1;
                end else if (op_q == OP_SET) begin
                    flags_d[idx_q] = 1'b1;
                end else if (op_q == OP_CLR) begin
                    flags_d[idx_q] = 1'b0;
                end
            end
            RESP: begin
                // flags_q already holds the post-update value here.
                state_d       = IDLE;
                ack_d[win_q]  = 1'b1;
                rdata_d       = idx_ok ? flags_q[idx_q] : 1'b0;
                err_d         = errl_q;
`ifdef SR_RR_ARB_EN
                rr_d = (win_q == PTRW'(NREQ - 1)) ? '0 : win_q + PTRW'(1);
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            op_q    <= '0;
            idx_q   <= '0;
            errl_q  <= 1'b0;
            flags_q <= '0;
            ack_q   <= '0;
            rdata_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            errl_q  <= errl_d;
            flags_q <= flags_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

`ifdef SR_RR_ARB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign err   = err_q;
    assign flags = flags_q;
    assign busy  = (state_q != IDLE);

endmodule
